// File: rtl/mp64_timer_arb_pkg.sv
// Timer MMIO byte offsets, arbiter opcodes and FSM encoding shared by the timer arbiter.
package mp64_timer_arb_pkg;

    localparam logic [3:0] TIMER_COUNT  = 4'h0;
    localparam logic [3:0] TIMER_CMP    = 4'h4;
    localparam logic [3:0] TIMER_CTRL   = 4'h8;
    localparam logic [3:0] TIMER_STATUS = 4'h9;
    localparam logic [7:0] STATUS_MATCH = 8'h01;

    typedef enum logic [1:0] {
        OP_WR_CMP    = 2'd0,
        OP_WR_CTRL   = 2'd1,
        OP_RD_COUNT  = 2'd2,
        OP_CLR_MATCH = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index of the final byte access an opcode performs.
    function automatic logic [1:0] op_last_byte(input op_e op);
        return (op == OP_WR_CMP || op == OP_RD_COUNT) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/mp64_timer_arb_rr_arb2.sv
// Two-way round-robin grant with a pointer that moves past the last winner.
// Latency: combinational grant, pointer updates on the granting edge.
// Backpressure: no grant while en is low; requests are simply held off.
module mp64_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (ptr == 1'b0) begin
                gnt = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
            end else begin
                gnt = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/mp64_timer_arb.sv
// Arbitrates two requesters onto the byte-wide timer MMIO port, one command at a time.
// Latency: accept at T, t_req at T+1, T+3.., rsp_valid one cycle after the last ack.
// Backpressure: cmd_ready only pulses in IDLE; a stalled t_ack aborts after TMO wait cycles.
module mp64_timer_arb #(
    parameter int NREQ = 2,
    parameter int TMO  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   cmd_valid,
    input  logic [2*NREQ-1:0] cmd_op,
    input  logic [32*NREQ-1:0] cmd_data,
    output logic [NREQ-1:0]   cmd_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              t_req,
    output logic              t_wen,
    output logic [3:0]        t_addr,
    output logic [7:0]        t_wdata,
    input  logic [7:0]        t_rdata,
    input  logic              t_ack
);

    import mp64_timer_arb_pkg::*;

    localparam logic [3:0] WAIT_LAST = 4'(TMO - 1);

    state_e      state, state_nxt;
    logic [1:0]  gnt;
    logic        arb_en;
    logic        sel;
    logic        sel_q;
    op_e         op_q;
    logic [31:0] data_q;
    logic [31:0] rd_q;
    logic [1:0]  byte_q;
    logic [3:0]  wait_q;
    logic        err_q;
    logic        last_byte;

    // Holding arb_en low during reset keeps cmd_ready quiet while state is forced to IDLE.
    assign arb_en    = (state == ST_IDLE) && rst_n;
    assign sel       = gnt[1];
    assign last_byte = (byte_q == op_last_byte(op_q));

    mp64_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (cmd_valid),
        .en    (arb_en),
        .gnt   (gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|gnt) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (t_ack) begin
                    state_nxt = last_byte ? ST_DONE : ST_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sel_q  <= 1'b0;
            op_q   <= OP_WR_CMP;
            data_q <= 32'h0;
            rd_q   <= 32'h0;
            byte_q <= 2'd0;
            wait_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        sel_q  <= sel;
                        op_q   <= op_e'(cmd_op[{sel, 1'b0} +: 2]);
                        data_q <= cmd_data[{sel, 5'b00000} +: 32];
                        rd_q   <= 32'h0;
                        byte_q <= 2'd0;
                        err_q  <= 1'b0;
                    end
                end
                ST_ISSUE: wait_q <= 4'd0;
                ST_WAIT: begin
                    if (t_ack) begin
                        if (op_q == OP_RD_COUNT) rd_q[{byte_q, 3'b000} +: 8] <= t_rdata;
                        if (!last_byte) byte_q <= byte_q + 2'd1;
                    end else if (wait_q == WAIT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and write data come straight from the latched command so they hold from ISSUE through the ack.
    always_comb begin
        t_addr  = 4'h0;
        t_wdata = 8'h00;
        t_wen   = 1'b0;
        if (state == ST_ISSUE || state == ST_WAIT) begin
            t_wen = (op_q != OP_RD_COUNT);
            case (op_q)
                OP_WR_CMP: begin
                    t_addr  = TIMER_CMP + {2'b00, byte_q};
                    t_wdata = data_q[{byte_q, 3'b000} +: 8];
                end
                OP_WR_CTRL: begin
                    t_addr  = TIMER_CTRL;
                    t_wdata = data_q[7:0];
                end
                OP_RD_COUNT: t_addr = TIMER_COUNT + {2'b00, byte_q};
                default: begin
                    t_addr  = TIMER_STATUS;
                    t_wdata = STATUS_MATCH;
                end
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == ST_DONE) rsp_valid[sel_q] = 1'b1;
    end

    assign cmd_ready = gnt;
    assign rsp_data  = (state == ST_DONE) ? rd_q : 32'h0;
    assign rsp_err   = (state == ST_DONE) && err_q;
    assign busy      = (state != ST_IDLE);
    assign t_req     = (state == ST_ISSUE);

endmodule

// File: tb/tb_mp64_timer_arb.sv
// Randomised scoreboard bench for mp64_timer_arb with a behavioural timer and arbiter model.
`timescale 1ns/1ps
module tb_mp64_timer_arb;
    import mp64_timer_arb_pkg::*;

    localparam int TMO = 15;

    typedef struct {
        logic [3:0] addr;
        logic       wen;
        logic [7:0] wdata;
    } mmio_t;

    typedef struct {
        int          req;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd_valid = 2'b00;
    logic [3:0]  cmd_op = 4'h0;
    logic [63:0] cmd_data = 64'h0;
    logic [1:0]  cmd_ready, rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err, busy, t_req, t_wen;
    logic [3:0]  t_addr;
    logic [7:0]  t_wdata;
    logic [7:0]  t_rdata = 8'h00;
    logic        t_ack_m = 1'b0;
    logic        spur = 1'b0;

    mp64_timer_arb #(.NREQ(2), .TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .t_req     (t_req),
        .t_wen     (t_wen),
        .t_addr    (t_addr),
        .t_wdata   (t_wdata),
        .t_rdata   (t_rdata),
        .t_ack     (t_ack_m | spur)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    checks = 0;
    int    errors = 0;
    int    force_delay = 1;   // -1: random per byte, 0: never ack, N: ack N cycles after req
    int    mmio_seen = 0;
    logic  rr_ptr = 1'b0;
    logic [7:0] mem [16];
    mmio_t exp_mmio [$];
    int    delay_q [$];
    rsp_t  exp_rsp [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference model: derive the byte accesses and the response from the opcode rules.
    task automatic accept(input int r, input logic [1:0] op, input logic [31:0] d, input int t);
        int          n;
        int          lat;
        logic [31:0] rd;
        logic        err;
        rsp_t        e;
        n   = (op == OP_WR_CMP || op == OP_RD_COUNT) ? 4 : 1;
        lat = 0;
        rd  = 32'h0;
        err = 1'b0;
        for (int k = 0; k < n; k++) begin
            int    dl;
            mmio_t m;
            if (force_delay >= 0) dl = force_delay;
            else dl = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
            m.wen = (op != OP_RD_COUNT);
            m.wdata = 8'h00;
            case (op)
                OP_WR_CMP:   begin m.addr = 4'(TIMER_CMP + k); m.wdata = d[8*k +: 8]; end
                OP_WR_CTRL:  begin m.addr = TIMER_CTRL; m.wdata = d[7:0]; end
                OP_RD_COUNT: m.addr = 4'(TIMER_COUNT + k);
                default:     begin m.addr = TIMER_STATUS; m.wdata = 8'h01; end
            endcase
            exp_mmio.push_back(m);
            delay_q.push_back(dl);
            if (dl == 0) begin
                lat += 1 + TMO;
                err = 1'b1;
                break;
            end
            lat += 1 + dl;
            if (op == OP_RD_COUNT) rd[8*k +: 8] = mem[4'(TIMER_COUNT + k)];
        end
        e.req = r; e.data = rd; e.err = err; e.cyc = t + lat + 1;
        exp_rsp.push_back(e);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] op0, input logic [31:0] d0,
                         input logic [1:0] op1, input logic [31:0] d1, input bit drain);
        logic [1:0] pend;
        int         w;
        pend = v;
        @(negedge clk);
        cmd_op = {op1, op0};
        cmd_data = {d1, d0};
        cmd_valid = pend;
        for (int n = 0; n < 600 && pend != 2'b00; n++) begin
            #1;
            if (cmd_ready != 2'b00) begin
                w = pend[rr_ptr] ? int'(rr_ptr) : int'(!rr_ptr);
                chk("grant", cmd_ready, 2'b01 << w);
                accept(w, (w == 1) ? op1 : op0, (w == 1) ? d1 : d0, cyc);
                rr_ptr = (w == 0);
                pend = pend & ~cmd_ready;
            end
            @(negedge clk);
            cmd_valid = pend;
        end
        if (pend != 2'b00) begin
            fail("grant_timeout");
            cmd_valid = 2'b00;
        end
        if (drain) begin
            for (int n = 0; n < 300 && exp_rsp.size() != 0; n++) @(negedge clk);
            if (exp_rsp.size() != 0) begin
                fail("rsp_timeout");
                exp_rsp.delete();
                exp_mmio.delete();
                delay_q.delete();
            end
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_cmd_ready"}, cmd_ready, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_data"},  rsp_data, 0);
        chk({pfx, "_rsp_err"},   rsp_err, 0);
        chk({pfx, "_busy"},      busy, 0);
        chk({pfx, "_t_req"},     t_req, 0);
        chk({pfx, "_t_wen"},     t_wen, 0);
        chk({pfx, "_t_addr"},    t_addr, 0);
        chk({pfx, "_t_wdata"},   t_wdata, 0);
    endtask

    // Timer model: checks each access against the expected list and acks after the planned delay.
    initial begin : timer_model
        int         pend;
        logic [3:0] a;
        logic       w;
        logic [7:0] wd;
        mmio_t      m;
        pend = 0; a = 4'h0; w = 1'b0; wd = 8'h00;
        forever begin
            @(negedge clk);
            t_ack_m = 1'b0;
            #1;
            if (!rst_n) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                chk("req_low_in_wait", t_req, 0);
                if (pend == 0) begin
                    chk("hold_addr", t_addr, a);
                    chk("hold_wen", t_wen, w);
                    chk("hold_wdata", t_wdata, wd);
                    t_ack_m = 1'b1;
                    t_rdata = mem[a];
                    if (w) mem[a] = wd;
                end
            end else if (t_req) begin
                a = t_addr; w = t_wen; wd = t_wdata;
                mmio_seen++;
                if (exp_mmio.size() == 0) begin
                    fail("mmio_unexpected");
                end else begin
                    m = exp_mmio.pop_front();
                    chk("mmio_addr", a, m.addr);
                    chk("mmio_wen", w, m.wen);
                    if (m.wen) chk("mmio_wdata", wd, m.wdata);
                end
                pend = (delay_q.size() != 0) ? delay_q.pop_front() : 1;
            end
        end
    end

    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid != 2'b00) begin
                if (exp_rsp.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_sel", rsp_valid, 2'b01 << e.req);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_expired (cycle %0d)", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int base;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        cmd_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        cmd_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Contested first request after reset goes to requester 0, then requester 1.
        force_delay = 1;
        drive(2'b11, OP_WR_CTRL, 32'h0000_0007, OP_CLR_MATCH, 32'h0, 1);
        chk("ctrl_reg", mem[TIMER_CTRL], 8'h07);
        chk("status_reg", mem[TIMER_STATUS], 8'h01);

        drive(2'b01, OP_WR_CMP, 32'h0000_C350, OP_WR_CMP, 32'h0, 1);
        chk("cmp_reg", {mem[7], mem[6], mem[5], mem[4]}, 32'h0000_C350);

        // Pointer now sits on requester 1 after the lone requester-0 grant.
        drive(2'b11, OP_WR_CTRL, 32'h0000_0003, OP_WR_CTRL, 32'h0000_0009, 1);
        chk("ctrl_reg_last", mem[TIMER_CTRL], 8'h03);

        mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
        drive(2'b01, OP_RD_COUNT, 32'h0, OP_RD_COUNT, 32'h0, 1);

        // Timer never answers: one access, then an error response; the following command is normal.
        force_delay = 0;
        drive(2'b10, OP_WR_CMP, 32'h0, OP_WR_CMP, 32'hAABB_CCDD, 1);
        force_delay = 1;
        drive(2'b10, OP_WR_CTRL, 32'h0, OP_WR_CTRL, 32'h0000_0005, 1);
        chk("ctrl_after_tmo", mem[TIMER_CTRL], 8'h05);

        repeat (4) begin
            @(negedge clk);
            spur = 1'b1;
            #1;
            chk("spur_busy", busy, 0);
            chk("spur_t_req", t_req, 0);
            chk("spur_rsp_valid", rsp_valid, 0);
            chk("spur_cmd_ready", cmd_ready, 0);
        end
        @(negedge clk);
        spur = 1'b0;
        drive(2'b01, OP_CLR_MATCH, 32'h0, OP_CLR_MATCH, 32'h0, 1);

        // Reset while waiting on the second byte of a compare write.
        force_delay = 8;
        base = mmio_seen;
        drive(2'b01, OP_WR_CMP, 32'h1122_3344, OP_WR_CMP, 32'h0, 0);
        for (int n = 0; n < 100 && mmio_seen < base + 2; n++) begin
            @(negedge clk);
            #2;
        end
        if (mmio_seen < base + 2) fail("second_byte_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        exp_mmio.delete();
        delay_q.delete();
        exp_rsp.delete();
        #2;
        chk_quiet("midop_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rr_ptr = 1'b0;
        force_delay = 1;
        drive(2'b01, OP_WR_CMP, 32'hDEAD_BEEF, OP_WR_CMP, 32'h0, 1);
        chk("cmp_after_reset", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEAD_BEEF);

        force_delay = -1;
        for (int it = 0; it < 40; it++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
            drive(v, 2'($urandom), $urandom, 2'($urandom), $urandom, 1);
        end

        repeat (3) @(negedge clk);
        if (exp_mmio.size() != 0) fail("mmio_leftover");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
